// File: rtl/id_pkg.sv
// Shared constants for the ID-stage hazard scoreboard and for decode, which
// drives issue_lat from the LAT_* values below.
package id_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int LW   = 3;

  localparam logic [LW-1:0] LAT_ALU  = 3'd0;
  localparam logic [LW-1:0] LAT_LOAD = 3'd1;
  localparam logic [LW-1:0] LAT_MUL  = 3'd2;
  localparam logic [LW-1:0] LAT_MAX  = 3'd7;

endpackage

// File: rtl/id_scoreboard_if.sv
// Decode/completion/read-port bundle of the scoreboard. Decode is the master;
// the scoreboard is the slave and returns the per-port busy flags.
interface id_scoreboard_if #(
  parameter int AW  = 5,
  parameter int LW  = 3,
  parameter int NRD = 2
) ();

  logic              issue_valid;
  logic              issue_we;
  logic [AW-1:0]     issue_waddr;
  logic [LW-1:0]     issue_lat;
  logic              issue_long;
  logic              long_done;
  logic [AW-1:0]     long_waddr;
  logic [NRD-1:0]    rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD-1:0]    rd_busy;
  logic              stallreq;

  modport master (
    output issue_valid, issue_we, issue_waddr, issue_lat, issue_long,
    output long_done, long_waddr, rd_en, rd_addr,
    input  rd_busy, stallreq
  );

  modport slave (
    input  issue_valid, issue_we, issue_waddr, issue_lat, issue_long,
    input  long_done, long_waddr, rd_en, rd_addr,
    output rd_busy, stallreq
  );

endinterface

// File: rtl/id_scoreboard_entry.sv
// One architectural register's pending state: a fixed-latency countdown plus
// a long-latency flag that stays set until the completion side clears it.
module sb_entry #(
  parameter int LW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          i_load,
  input  logic [LW-1:0] i_lat,
  input  logic          i_set_long,
  input  logic          i_clr_long,
  output logic          o_pending
);

  logic [LW-1:0] r_cnt;
  logic          r_lng;
  logic [LW-1:0] w_cnt_dec;
  logic [LW-1:0] w_cnt_next;

  // NOTE: every signal driven here gets a value on every path, so no latch.
  always_comb begin
    w_cnt_dec = r_cnt;
    if (!hold && r_cnt != '0) w_cnt_dec = r_cnt - 1'b1;
    w_cnt_next = w_cnt_dec;
    // A newer, faster write must never shorten an older, slower one.
    if (i_load && i_lat > w_cnt_dec) w_cnt_next = i_lat;
  end

  // NOTE: state is updated with <= so every entry samples the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
      r_lng <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      if (i_set_long)      r_lng <= 1'b1;
      else if (i_clr_long) r_lng <= 1'b0;
    end
  end

  assign o_pending = (r_cnt != '0) | r_lng;

endmodule

// File: rtl/id_scoreboard.sv
// Register-hazard scoreboard beside the ID stage: tracks pending results per
// register and raises the decode stall request for busy source operands.
module id_scoreboard #(
  parameter int NREG    = id_pkg::NREG,
  parameter int AW      = id_pkg::AW,
  parameter int NRD     = 2,
  parameter int MAX_LAT = 7,
  parameter int LW      = id_pkg::LW,
  parameter int PCW     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  id_scoreboard_if.slave   sb,
  output logic [NREG-1:0]  busy_vec,
  output logic [PCW-1:0]   stall_cnt
);

  if (AW != $clog2(NREG)) begin : g_bad_aw
    $error("id_scoreboard: AW must equal clog2(NREG)");
  end
  if (LW != $clog2(MAX_LAT + 1)) begin : g_bad_lw
    $error("id_scoreboard: LW must equal clog2(MAX_LAT+1)");
  end

  logic [NREG-1:0] w_pend;
  logic            w_issue;
  logic [NRD-1:0]  w_rd_busy;
  logic            w_stallreq;
  logic [PCW-1:0]  r_stall_cnt;

  assign w_issue   = sb.issue_valid & sb.issue_we;
  assign w_pend[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    logic w_hit;
    logic w_clr;
    assign w_hit = w_issue && (sb.issue_waddr == AW'(r));
    assign w_clr = sb.long_done && (sb.long_waddr == AW'(r));

    sb_entry #(.LW(LW)) u_entry (
      .clk        (clk),
      .rst        (rst),
      .hold       (hold),
      .i_load     (w_hit & ~sb.issue_long),
      .i_lat      (sb.issue_lat),
      .i_set_long (w_hit & sb.issue_long),
      .i_clr_long (w_clr),
      .o_pending  (w_pend[r])
    );
  end

  // Same-cycle response: the ID stall path cannot tolerate a registered busy.
  always_comb begin
    w_rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      w_rd_busy[i] = sb.rd_en[i] & w_pend[sb.rd_addr[i*AW +: AW]];
    end
  end

  assign w_stallreq = |w_rd_busy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_stallreq && r_stall_cnt != '1) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign sb.rd_busy  = w_rd_busy;
  assign sb.stallreq = w_stallreq;
  assign busy_vec    = w_pend;
  assign stall_cnt   = r_stall_cnt;

endmodule
